// File: rtl/mux_arb_ctrl.sv
// Round-robin arbiter sharing a 4:1 nibble channel; each grant lasts HOLD_CYCLES cycles, q lags d by one cycle.
// Latency: request to gnt/sel in 1 edge; min 2-cycle gap (RELEASE + IDLE); early drop of req[sel] ends the grant at once.
// Optional MUX_ARB_COM_PRIO_EN: channel 0 wins strictly in IDLE, channels 1..3 rotate among themselves.
module mux_arb_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic [3:0] done,
    output logic [4:0] q,
    output logic       valid
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       last, last_nxt;
    logic [1:0]       sel_nxt;
    logic [3:0]       gnt_nxt, done_nxt;
    logic [4:0]       q_nxt;
    logic             valid_nxt;
    logic [3:0]       dsel;
    logic [1:0]       cand, pick_idx;
    logic             pick_vld;

    always_comb begin
        case (sel)
            2'd0:    dsel = d1;
            2'd1:    dsel = d2;
            2'd2:    dsel = d3;
            default: dsel = d4;
        endcase
    end

    // First requester after 'last' wins; ascending scan keeps the earliest hit.
    always_comb begin
        cand     = last;
        pick_vld = 1'b0;
        pick_idx = 2'd0;
`ifdef MUX_ARB_COM_PRIO_EN
        if (req[0]) begin
            pick_vld = 1'b1;
            pick_idx = 2'd0;
        end
        for (int i = 0; i < 3; i++) begin
            cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
`else
        for (int i = 0; i < 4; i++) begin
            cand = cand + 2'd1;
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        done_nxt  = 4'b0000;
        q_nxt     = q;
        valid_nxt = valid;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    sel_nxt   = pick_idx;
                    gnt_nxt   = 4'b0001 << pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                q_nxt     = {sel != 2'd0, dsel};
                valid_nxt = 1'b1;
                cnt_nxt   = cnt + 1'b1;
                // Early drop outranks dwell completion and suppresses done.
                if (!req[sel] || cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = 4'b0000;
                    valid_nxt = 1'b0;
`ifdef MUX_ARB_COM_PRIO_EN
                    if (sel != 2'd0) last_nxt = sel;
`else
                    last_nxt = sel;
`endif
                    if (req[sel]) done_nxt[sel] = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 2'd3;
            sel   <= 2'd0;
            gnt   <= 4'b0000;
            done  <= 4'b0000;
            q     <= 5'b00000;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            q     <= q_nxt;
            valid <= valid_nxt;
        end
    end
endmodule

// File: tb/tb_mux_arb_ctrl.sv
// Directed bench for mux_arb_ctrl with HOLD_CYCLES=4; outputs sampled 1 time unit after each rising edge.
module tb_mux_arb_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, d1, d2, d3, d4;
    logic [1:0] sel;
    logic [3:0] gnt, done;
    logic [4:0] q;
    logic       valid;
    int         total = 0;
    int         bad   = 0;

    mux_arb_ctrl #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .sel(sel), .gnt(gnt), .done(done), .q(q), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b0000;
        d1 = 4'h0; d2 = 4'h0; d3 = 4'h0; d4 = 4'h0;
        tick;
        tick;
        total++;
        if ({sel, gnt, done, valid, q} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state got=%h want=0000", {sel, gnt, done, valid, q});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({sel, gnt, done, valid, q} !== 16'h0000) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got=%h want=0000", i, {sel, gnt, done, valid, q});
            end
        end
    endtask

    task automatic test_single;
        logic [3:0] eg, ed;
        logic       ev;
        req = 4'b0100; d3 = 4'hA;
        for (int j = 0; j < 7; j++) begin
            tick;
            eg = (j < 4 || j == 6) ? 4'b0100 : 4'b0000;
            ed = (j == 4) ? 4'b0100 : 4'b0000;
            ev = (j >= 1 && j <= 3);
            total++;
            if ({gnt, done, valid} !== {eg, ed, ev}) begin
                bad++;
                $display("FAIL single_ctrl cyc=%0d got gnt=%b done=%b valid=%b want gnt=%b done=%b valid=%b",
                         j, gnt, done, valid, eg, ed, ev);
            end
            if (ev) begin
                total++;
                if ({sel, q} !== {2'd2, 5'h1A}) begin
                    bad++;
                    $display("FAIL single_data cyc=%0d got sel=%0d q=%h want sel=2 q=1a", j, sel, q);
                end
            end
        end
        req = 4'b0000;
        tick;
        tick;
    endtask

    // Runs n back-to-back full-dwell grants and checks each against order[].
    task automatic run_grants(input int n, input int order[6], input int drop_at);
        logic [3:0] oh;
        logic [4:0] eq;
        for (int g = 0; g < n; g++) begin
            if (g == drop_at) req[0] = 1'b0;
            oh = 4'b0001 << order[g];
            eq = {order[g] != 0, 4'(order[g] + 1)};
            tick;
            total++;
            if ({sel, gnt, done} !== {2'(order[g]), oh, 4'b0000}) begin
                bad++;
                $display("FAIL grant_pick g=%0d got sel=%0d gnt=%b done=%b want sel=%0d gnt=%b",
                         g, sel, gnt, done, order[g], oh);
            end
            tick;
            total++;
            if ({valid, q} !== {1'b1, eq}) begin
                bad++;
                $display("FAIL grant_q g=%0d got valid=%b q=%h want valid=1 q=%h", g, valid, q, eq);
            end
            tick;
            tick;
            tick;
            total++;
            if ({gnt, done, valid} !== {4'b0000, oh, 1'b0}) begin
                bad++;
                $display("FAIL grant_done g=%0d got gnt=%b done=%b valid=%b want gnt=0000 done=%b",
                         g, gnt, done, valid, oh);
            end
            tick;
            total++;
            if ({gnt, done} !== 8'h00) begin
                bad++;
                $display("FAIL grant_gap g=%0d got gnt=%b done=%b want 0", g, gnt, done);
            end
        end
    endtask

    task automatic test_round_robin;
        do_reset;
        req = 4'b1111;
        d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; d4 = 4'h4;
        run_grants(5, '{0, 1, 2, 3, 0, 0}, 99);
        req = 4'b0000;
        tick;
        tick;
        tick;
    endtask

    task automatic test_com_prio;
        do_reset;
        req = 4'b1011;
        d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; d4 = 4'h4;
        run_grants(6, '{0, 0, 1, 3, 1, 3}, 2);
        req = 4'b0000;
        tick;
        tick;
        tick;
    endtask

    task automatic test_early_drop;
        do_reset;
        req = 4'b1010; d2 = 4'h2;
        tick;
        tick;
        total++;
        if ({gnt, valid, q} !== {4'b0010, 1'b1, 5'h12}) begin
            bad++;
            $display("FAIL drop_pre got gnt=%b valid=%b q=%h want gnt=0010 valid=1 q=12", gnt, valid, q);
        end
        req = 4'b1000;
        tick;
        total++;
        if ({gnt, done, valid} !== 9'h000) begin
            bad++;
            $display("FAIL drop_edge got gnt=%b done=%b valid=%b want all 0", gnt, done, valid);
        end
        tick;
        total++;
        if ({gnt, done} !== 8'h00) begin
            bad++;
            $display("FAIL drop_nodone got gnt=%b done=%b want 0", gnt, done);
        end
        tick;
        total++;
        if ({sel, gnt} !== {2'd3, 4'b1000}) begin
            bad++;
            $display("FAIL drop_next got sel=%0d gnt=%b want sel=3 gnt=1000", sel, gnt);
        end
        req = 4'b0000;
        tick;
        tick;
    endtask

    task automatic test_reset_mid;
        do_reset;
        req = 4'b0100; d3 = 4'h3;
        tick;
        tick;
        tick;
        rst = 1'b1;
        req = 4'b0110;
        tick;
        total++;
        if ({sel, gnt, done, valid, q} !== 16'h0000) begin
            bad++;
            $display("FAIL midrst_state got=%h want=0000", {sel, gnt, done, valid, q});
        end
        rst = 1'b0;
        tick;
        total++;
        if ({sel, gnt, done} !== {2'd1, 4'b0010, 4'b0000}) begin
            bad++;
            $display("FAIL midrst_next got sel=%0d gnt=%b done=%b want sel=1 gnt=0010", sel, gnt, done);
        end
        req = 4'b0000;
        tick;
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
`ifdef MUX_ARB_COM_PRIO_EN
        test_com_prio;
`else
        test_round_robin;
`endif
        test_early_drop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
